// File: rtl/conv1d_pkg.sv
// Shared definitions for the parametrised 1D convolution core: host conf codes,
// STATUS/CTRL bit positions, FSM states and the accumulator sizing rule.
package conv1d_pkg;

  localparam int CONF_MEM_X  = 0;
  localparam int CONF_MEM_Y  = 1;
  localparam int CONF_SIZE_X = 2;
  localparam int CONF_SIZE_Y = 3;
  localparam int CONF_MEM_Z  = 4;
  localparam int CONF_STATUS = 5;
  localparam int CONF_CTRL   = 6;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_INT_EN  = 0;
  localparam int CTRL_SIGNED  = 1;
  localparam int CTRL_INT_CLR = 2;

  typedef enum logic [2:0] {IDLE, CHECK, CLEAR, MAC, STORE, DONE} convStateT;

  // Wide enough that Y_DEPTH full-scale products can never overflow.
  function automatic int accWidth(input int sampleW, input int yDepth);
    return 2 * sampleW + $clog2(yDepth);
  endfunction

endpackage

// File: rtl/conv1d_mac.sv
// Signed/unsigned multiply-accumulate with clear, plus the store-stage reduction
// to OUT_W bits (clamp when CONV1D_SAT_EN is defined, otherwise wrap).
module conv1d_mac
  import conv1d_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = accWidth(8, 32)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                clr,
  input  logic                accEn,
  input  logic                signedMode,
  input  logic [SAMPLE_W-1:0] sampleA,
  input  logic [SAMPLE_W-1:0] sampleB,
  output logic [OUT_W-1:0]    storeVal
);

  logic signed [SAMPLE_W:0] aExt_p0;
  logic signed [SAMPLE_W:0] bExt_p0;
  logic signed [ACC_W-1:0]  prod_p0;
  logic signed [ACC_W-1:0]  acc_p1;

  // One extra bit lets the same signed multiplier serve both modes.
  assign aExt_p0 = $signed({signedMode & sampleA[SAMPLE_W-1], sampleA});
  assign bExt_p0 = $signed({signedMode & sampleB[SAMPLE_W-1], sampleB});
  assign prod_p0 = ACC_W'(aExt_p0) * ACC_W'(bExt_p0);

  // p0 -> p1: accumulator register
  always_ff @(posedge clk) begin
    if (en) begin
      if (clr) begin
        acc_p1 <= '0;
      end else if (accEn) begin
        acc_p1 <= acc_p1 + prod_p0;
      end
    end
  end

`ifdef CONV1D_SAT_EN
  function automatic logic [OUT_W-1:0] satStore(input logic signed [ACC_W-1:0] v,
                                                input logic sgn);
    logic signed [ACC_W-1:0] sMax;
    logic signed [ACC_W-1:0] sMin;
    logic        [ACC_W-1:0] uMax;
    logic        [ACC_W-1:0] vU;
    sMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    sMin = ~sMax;
    uMax = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    vU   = v;
    if (sgn) begin
      if (v > sMax)      return sMax[OUT_W-1:0];
      else if (v < sMin) return sMin[OUT_W-1:0];
      else               return v[OUT_W-1:0];
    end else begin
      if (vU > uMax)     return '1;
      else               return vU[OUT_W-1:0];
    end
  endfunction

  assign storeVal = satStore(acc_p1, signedMode);
`else
  function automatic logic [OUT_W-1:0] truncStore(input logic signed [ACC_W-1:0] v);
    return v[OUT_W-1:0];
  endfunction

  assign storeVal = truncStore(acc_p1);
`endif

endmodule

// File: rtl/conv1d_engine_param.sv
// Parametrised 1D convolution core z[n] = sum_k x[k]*y[n-k] behind a conf/data
// host strobe interface. Define CONV1D_SAT_EN to clamp stored results to OUT_W.
module conv1d_engine_param
  import conv1d_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CONF_W   = 5,
  parameter int SAMPLE_W = 8,
  parameter int X_DEPTH  = 32,
  parameter int Y_DEPTH  = 32,
  parameter int OUT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_s,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              write,
  input  logic              read,
  input  logic              start,
  input  logic [CONF_W-1:0] conf_dbus,
  output logic              int_req,
  output logic              busy
);

  localparam int Z_DEPTH = X_DEPTH + Y_DEPTH - 1;
  localparam int XP_W    = (X_DEPTH > 1) ? $clog2(X_DEPTH) : 1;
  localparam int YP_W    = (Y_DEPTH > 1) ? $clog2(Y_DEPTH) : 1;
  localparam int ZP_W    = $clog2(Z_DEPTH);
  localparam int ACC_W   = accWidth(SAMPLE_W, Y_DEPTH);

  localparam logic [CONF_W-1:0] cMemX   = CONF_W'(CONF_MEM_X);
  localparam logic [CONF_W-1:0] cMemY   = CONF_W'(CONF_MEM_Y);
  localparam logic [CONF_W-1:0] cSizeX  = CONF_W'(CONF_SIZE_X);
  localparam logic [CONF_W-1:0] cSizeY  = CONF_W'(CONF_SIZE_Y);
  localparam logic [CONF_W-1:0] cMemZ   = CONF_W'(CONF_MEM_Z);
  localparam logic [CONF_W-1:0] cStatus = CONF_W'(CONF_STATUS);
  localparam logic [CONF_W-1:0] cCtrl   = CONF_W'(CONF_CTRL);

  convStateT state, nextState;

  logic [SAMPLE_W-1:0] memX [X_DEPTH];
  logic [SAMPLE_W-1:0] memY [Y_DEPTH];
  logic [OUT_W-1:0]    memZ [Z_DEPTH];

  logic [CONF_W-1:0] confPrev;
  logic              confChg;
  logic [XP_W-1:0]   ptrX, xEff, xNext;
  logic [YP_W-1:0]   ptrY, yEff, yNext;
  logic [ZP_W-1:0]   ptrZ, zEff, zNext;

  logic [DATA_W-1:0] sizeX, sizeY;
  logic              modeSigned, intEn, doneFlag, errFlag, intReq;

  logic [ZP_W-1:0]   nIdx;
  logic [YP_W-1:0]   kIdx;
  logic [DATA_W-1:0] nW, kW, jW;
  logic [XP_W-1:0]   xIdx;
  logic              sizesOk, lastK, lastN, tapValid;

  logic              startOk, macClr, macAcc, zWe, setErr, setDone;
  logic              hostRd;
  logic [DATA_W-1:0] rdData;
  logic [OUT_W-1:0]  zRd, zStore;
  logic [SAMPLE_W-1:0] xSample, ySample;

  assign busy    = (state != IDLE);
  assign int_req = intReq;
  assign hostRd  = read & ~write;

  // Pointers read as zero on the very cycle the target changes.
  assign confChg = (conf_dbus != confPrev);
  assign xEff    = confChg ? '0 : ptrX;
  assign yEff    = confChg ? '0 : ptrY;
  assign zEff    = confChg ? '0 : ptrZ;
  assign xNext   = (xEff == XP_W'(X_DEPTH-1)) ? '0 : xEff + XP_W'(1);
  assign yNext   = (yEff == YP_W'(Y_DEPTH-1)) ? '0 : yEff + YP_W'(1);
  assign zNext   = (zEff == ZP_W'(Z_DEPTH-1)) ? '0 : zEff + ZP_W'(1);

  assign nW       = DATA_W'(nIdx);
  assign kW       = DATA_W'(kIdx);
  assign jW       = nW - kW;
  assign xIdx     = jW[XP_W-1:0];
  assign tapValid = (kW <= nW) && (jW < sizeX);
  assign sizesOk  = (sizeX != '0) && (sizeX <= DATA_W'(X_DEPTH)) &&
                    (sizeY != '0) && (sizeY <= DATA_W'(Y_DEPTH));
  assign lastK    = (kW == sizeY - DATA_W'(1));
  assign lastN    = (nW == sizeX + sizeY - DATA_W'(2));

  assign xSample = memX[xIdx];
  assign ySample = memY[kIdx];
  assign zRd     = memZ[zEff];

  always_comb begin
    nextState = state;
    startOk   = 1'b0;
    macClr    = 1'b0;
    macAcc    = 1'b0;
    zWe       = 1'b0;
    setErr    = 1'b0;
    setDone   = 1'b0;
    case (state)
      IDLE:  if (start) begin
               startOk   = 1'b1;
               nextState = CHECK;
             end
      CHECK: if (sizesOk) nextState = CLEAR;
             else begin
               setErr    = 1'b1;
               nextState = DONE;
             end
      CLEAR: begin
               macClr    = 1'b1;
               nextState = MAC;
             end
      MAC:   begin
               macAcc = tapValid;
               if (lastK) nextState = STORE;
             end
      STORE: begin
               zWe       = 1'b1;
               nextState = lastN ? DONE : CLEAR;
             end
      DONE:  begin
               setDone   = 1'b1;
               nextState = IDLE;
             end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rdData = '0;
    case (conf_dbus)
      cSizeX:  rdData = sizeX;
      cSizeY:  rdData = sizeY;
      cMemZ:   rdData = modeSigned ? {{(DATA_W-OUT_W){zRd[OUT_W-1]}}, zRd}
                                   : {{(DATA_W-OUT_W){1'b0}}, zRd};
      cStatus: begin
                 rdData[STAT_DONE] = doneFlag;
                 rdData[STAT_BUSY] = busy;
                 rdData[STAT_ERR]  = errFlag;
               end
      cCtrl:   begin
                 rdData[CTRL_INT_EN] = intEn;
                 rdData[CTRL_SIGNED] = modeSigned;
               end
      default: rdData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      confPrev   <= '0;
      ptrX       <= '0;
      ptrY       <= '0;
      ptrZ       <= '0;
      sizeX      <= DATA_W'(1);
      sizeY      <= DATA_W'(1);
      modeSigned <= 1'b0;
      intEn      <= 1'b0;
      doneFlag   <= 1'b0;
      errFlag    <= 1'b0;
      intReq     <= 1'b0;
      data_out   <= '0;
      nIdx       <= '0;
      kIdx       <= '0;
    end else if (en_s) begin
      state    <= nextState;
      confPrev <= conf_dbus;
      ptrX     <= xEff;
      ptrY     <= yEff;
      ptrZ     <= zEff;
      if (write) begin
        case (conf_dbus)
          cMemX:  if (!busy) ptrX <= xNext;
          cMemY:  if (!busy) ptrY <= yNext;
          cSizeX: sizeX <= data_in;
          cSizeY: sizeY <= data_in;
          cCtrl:  begin
                    intEn      <= data_in[CTRL_INT_EN];
                    modeSigned <= data_in[CTRL_SIGNED];
                    if (data_in[CTRL_INT_CLR]) intReq <= 1'b0;
                  end
          default: ;
        endcase
      end else if (hostRd) begin
        data_out <= rdData;
        if (conf_dbus == cMemZ) ptrZ <= zNext;
      end
      if (setErr) errFlag <= 1'b1;
      if (setDone) begin
        doneFlag <= 1'b1;
        if (intEn) intReq <= 1'b1;
      end
      if (startOk) begin
        ptrX     <= '0;
        ptrY     <= '0;
        ptrZ     <= '0;
        doneFlag <= 1'b0;
        errFlag  <= 1'b0;
        intReq   <= 1'b0;
      end
      case (state)
        CHECK:   nIdx <= '0;
        CLEAR:   kIdx <= '0;
        MAC:     kIdx <= kIdx + YP_W'(1);
        STORE:   if (!lastN) nIdx <= nIdx + ZP_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && en_s) begin
      if (write && !busy && conf_dbus == cMemX) memX[xEff] <= data_in[SAMPLE_W-1:0];
      if (write && !busy && conf_dbus == cMemY) memY[yEff] <= data_in[SAMPLE_W-1:0];
      if (zWe) memZ[nIdx] <= zStore;
    end
  end

  conv1d_mac #(
    .SAMPLE_W(SAMPLE_W),
    .OUT_W   (OUT_W),
    .ACC_W   (ACC_W)
  ) uMac (
    .clk       (clk),
    .en        (en_s),
    .clr       (macClr),
    .accEn     (macAcc),
    .signedMode(modeSigned),
    .sampleA   (xSample),
    .sampleB   (ySample),
    .storeVal  (zStore)
  );

endmodule

// File: tb/tb_conv1d_engine_param.sv
// Directed bench for conv1d_engine_param: host load/run/readback, signed mode,
// interrupt, error status, pointer wrap/reset, mid-run reset and clock enable.
module tb_conv1d_engine_param;

  logic        clk = 1'b0;
  logic        rst, en_s, write, read, start;
  logic [31:0] data_in, data_out;
  logic [4:0]  conf_dbus;
  logic        int_req, busy;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  always #5 clk = ~clk;

  conv1d_engine_param dut (
    .clk      (clk),
    .rst      (rst),
    .en_s     (en_s),
    .data_in  (data_in),
    .data_out (data_out),
    .write    (write),
    .read     (read),
    .start    (start),
    .conf_dbus(conf_dbus),
    .int_req  (int_req),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic hostWrite(input logic [4:0] c, input logic [31:0] d);
    conf_dbus = c;
    data_in   = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [4:0] c, input logic [31:0] exp);
    conf_dbus = c;
    read      = 1'b1;
    tick();
    read      = 1'b0;
    check(tag, data_out, exp);
  endtask

  task automatic waitIdle(input int base, output int n);
    n = base;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("busy_drop", {31'b0, busy}, 32'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    data_in = '0; conf_dbus = '0;
    repeat (2) tick();
    check("rst_data_out", data_out, 32'd0);
    check("rst_int_req", {31'b0, int_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    tick();
    readCheck("rst_size_x", 5'd2, 32'd1);
    readCheck("rst_size_y", 5'd3, 32'd1);
    readCheck("rst_status", 5'd5, 32'd0);
    readCheck("rst_ctrl", 5'd6, 32'd0);

    // Unsigned: X=[1,2,3], Y=[1,1] -> Z=[1,3,5,3], 18 cycles
    hostWrite(5'd6, 32'd0);
    hostWrite(5'd0, 32'd1); hostWrite(5'd0, 32'd2); hostWrite(5'd0, 32'd3);
    hostWrite(5'd1, 32'd1); hostWrite(5'd1, 32'd1);
    hostWrite(5'd2, 32'd3); hostWrite(5'd3, 32'd2);
    pulseStart();
    check("u_busy_run", {31'b0, busy}, 32'd1);
    waitIdle(0, cyc);
    check("u_cycles", cyc, 32'd18);
    check("u_int_req", {31'b0, int_req}, 32'd0);
    readCheck("u_status", 5'd5, 32'h1);
    readCheck("u_z0", 5'd4, 32'd1);
    readCheck("u_z1", 5'd4, 32'd3);
    readCheck("u_z2", 5'd4, 32'd5);
    readCheck("u_z3", 5'd4, 32'd3);

    // Signed with interrupt: X=[-2,3], Y=[4] -> Z=[-8,12]
    hostWrite(5'd6, 32'h3);
    hostWrite(5'd0, 32'hFE); hostWrite(5'd0, 32'h3);
    hostWrite(5'd1, 32'h4);
    hostWrite(5'd2, 32'd2); hostWrite(5'd3, 32'd1);
    pulseStart();
    waitIdle(0, cyc);
    check("s_cycles", cyc, 32'd8);
    check("s_int_set", {31'b0, int_req}, 32'd1);
    readCheck("s_z0", 5'd4, 32'hFFFF_FFF8);
    readCheck("s_z1", 5'd4, 32'h0000_000C);
    check("s_int_held", {31'b0, int_req}, 32'd1);
    hostWrite(5'd6, 32'h7);
    check("s_int_clr", {31'b0, int_req}, 32'd0);
    readCheck("s_ctrl", 5'd6, 32'h3);

    // Signed overflow: X=Y=[127 x4]
    hostWrite(5'd6, 32'h2);
    for (int i = 0; i < 4; i++) hostWrite(5'd0, 32'd127);
    for (int i = 0; i < 4; i++) hostWrite(5'd1, 32'd127);
    hostWrite(5'd2, 32'd4); hostWrite(5'd3, 32'd4);
    pulseStart();
    waitIdle(0, cyc);
    check("o_cycles", cyc, 32'd44);
    readCheck("o_z0", 5'd4, 32'h0000_3F01);
    readCheck("o_z1", 5'd4, 32'h0000_7E02);
    readCheck("o_z2", 5'd4, `ifdef CONV1D_SAT_EN 32'h0000_7FFF `else 32'hFFFF_BD03 `endif);
    readCheck("o_z3", 5'd4, `ifdef CONV1D_SAT_EN 32'h0000_7FFF `else 32'hFFFF_FC04 `endif);

    // Error path: SIZE_X=0
    hostWrite(5'd2, 32'd0);
    pulseStart();
    waitIdle(0, cyc);
    check("e_cycles", cyc, 32'd2);
    readCheck("e_status", 5'd5, 32'h5);
    readCheck("e_z0_kept", 5'd4, 32'h0000_3F01);

    // Second start while busy is ignored
    hostWrite(5'd2, 32'd2); hostWrite(5'd3, 32'd1);
    pulseStart();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitIdle(2, cyc);
    check("d_cycles", cyc, 32'd8);
    readCheck("d_status", 5'd5, 32'h1);

    // Pointer wrap past X_DEPTH, then pointer reset on conf change
    hostWrite(5'd6, 32'h0);
    for (int i = 0; i < 32; i++) hostWrite(5'd0, 32'(i + 1));
    hostWrite(5'd0, 32'h55);
    hostWrite(5'd1, 32'd1);
    hostWrite(5'd2, 32'd2); hostWrite(5'd3, 32'd1);
    pulseStart();
    waitIdle(0, cyc);
    readCheck("p_wrap_z0", 5'd4, 32'h55);
    readCheck("p_wrap_z1", 5'd4, 32'h2);
    hostWrite(5'd0, 32'h22);
    pulseStart();
    waitIdle(0, cyc);
    readCheck("p_reset_z0", 5'd4, 32'h22);
    readCheck("p_reset_z1", 5'd4, 32'h2);

    // Reset mid-MAC
    hostWrite(5'd6, 32'h1);
    hostWrite(5'd2, 32'd4); hostWrite(5'd3, 32'd4);
    pulseStart();
    repeat (5) tick();
    check("r_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("r_busy", {31'b0, busy}, 32'd0);
    check("r_int_req", {31'b0, int_req}, 32'd0);
    check("r_data_out", data_out, 32'd0);
    rst = 1'b1;
    readCheck("r_size_x", 5'd2, 32'd1);
    readCheck("r_ctrl", 5'd6, 32'd0);

    // Clock enable low for 5 cycles mid-run delays completion by 5
    hostWrite(5'd0, 32'd1); hostWrite(5'd0, 32'd2); hostWrite(5'd0, 32'd3);
    hostWrite(5'd1, 32'd1); hostWrite(5'd1, 32'd1);
    hostWrite(5'd2, 32'd3); hostWrite(5'd3, 32'd2);
    pulseStart();
    repeat (4) tick();
    en_s = 1'b0;
    repeat (5) tick();
    check("c_busy_frozen", {31'b0, busy}, 32'd1);
    en_s = 1'b1;
    waitIdle(9, cyc);
    check("c_cycles", cyc, 32'd23);
    readCheck("c_z0", 5'd4, 32'd1);
    readCheck("c_z1", 5'd4, 32'd3);
    readCheck("c_z2", 5'd4, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
